// File: rtl/ntt_poly_mult_stream_ctrl.sv
// Streaming front end for ntt_poly_mult. It loads one frame of 2*N input
// coefficients (A then B) into the core, starts the multiply, then reads
// the N results back and sends them out on a valid/ready stream.
module ntt_poly_mult_stream_ctrl #(
   parameter int unsigned N          = 256,
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned Q          = 8380417,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned TIMEOUT    = 1048576
) (
   input  logic                  clk,
   input  logic                  rst,
   // input coefficient stream
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   // result stream
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_last,
   // status
   output logic                  busy,
   output logic                  frame_done,
   output logic                  range_err,
   output logic                  timeout_err,
   // poly-mult core side
   output logic                  pm_start,
   input  logic                  pm_done,
   output logic                  pm_load_coeff,
   output logic                  pm_load_sel,
   output logic [ADDR_WIDTH-1:0] pm_load_addr,
   output logic [WIDTH-1:0]      pm_load_data,
   output logic [ADDR_WIDTH-1:0] pm_read_addr,
   input  logic [WIDTH-1:0]      pm_read_data
);

   localparam int unsigned BEAT_W = $clog2(2 * N + 1);
   localparam int unsigned LAT_W  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
   localparam int unsigned WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [WIDTH-1:0]      Q_W        = WIDTH'(Q);
   localparam logic [BEAT_W-1:0]     N_B        = BEAT_W'(N);
   localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(2 * N - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(N - 1);
   localparam logic [LAT_W-1:0]      LAT_DONE   = LAT_W'(RD_LAT);
   localparam logic [WD_W-1:0]       WD_LIMIT   = WD_W'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      RUN        = 3'd2,
      READ_ISSUE = 3'd3,
      READ_WAIT  = 3'd4,
      OUT        = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
   logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
   logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;

   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [WIDTH-1:0]      out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  busy_q, busy_d;
   logic                  frame_done_q, frame_done_d;
   logic                  range_err_q, range_err_d;
   logic                  timeout_err_q, timeout_err_d;
   logic                  pm_start_q, pm_start_d;
   logic                  pm_load_coeff_q, pm_load_coeff_d;
   logic                  pm_load_sel_q, pm_load_sel_d;
   logic [ADDR_WIDTH-1:0] pm_load_addr_q, pm_load_addr_d;
   logic [WIDTH-1:0]      pm_load_data_q, pm_load_data_d;
   logic [ADDR_WIDTH-1:0] pm_read_addr_q, pm_read_addr_d;

   logic                  accept_c;
   logic [BEAT_W-1:0]     load_idx_c;

   // in_ready_q is only ever high in IDLE/LOAD, so this is the input handshake
   assign accept_c   = in_valid && in_ready_q;
   // beat index of the beat being accepted; the IDLE beat is always index 0
   assign load_idx_c = (state_q == IDLE) ? '0 : beat_cnt_q;

   // next-state and next-output logic
   always_comb begin
      state_d         = state_q;
      beat_cnt_d      = beat_cnt_q;
      rd_idx_d        = rd_idx_q;
      lat_cnt_d       = lat_cnt_q;
      wd_cnt_d        = wd_cnt_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      out_last_d      = out_last_q;
      frame_done_d    = 1'b0;
      range_err_d     = range_err_q;
      timeout_err_d   = timeout_err_q;
      pm_start_d      = pm_start_q;
      pm_load_coeff_d = 1'b0;
      pm_load_sel_d   = pm_load_sel_q;
      pm_load_addr_d  = pm_load_addr_q;
      pm_load_data_d  = pm_load_data_q;
      pm_read_addr_d  = pm_read_addr_q;

      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               range_err_d   = 1'b0;
               timeout_err_d = 1'b0;
               beat_cnt_d    = BEAT_W'(1);
               state_d       = LOAD;
            end
         end

         LOAD: begin
            if (accept_c) begin
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               if (beat_cnt_q == LAST_BEAT) begin
                  wd_cnt_d = '0;
                  state_d  = RUN;
               end
            end
         end

         RUN: begin
            // pm_done only counts once start has actually been presented
            if (pm_start_q && pm_done) begin
               pm_start_d = 1'b0;
               rd_idx_d   = '0;
               state_d    = READ_ISSUE;
            end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LIMIT)) begin
               timeout_err_d = 1'b1;
               pm_start_d    = 1'b0;
               state_d       = IDLE;
            end else begin
               pm_start_d = 1'b1;
               wd_cnt_d   = wd_cnt_q + WD_W'(1);
            end
         end

         READ_ISSUE: begin
            pm_read_addr_d = rd_idx_q;
            lat_cnt_d      = '0;
            state_d        = READ_WAIT;
         end

         READ_WAIT: begin
            if (lat_cnt_q == LAT_DONE) begin
               out_data_d  = pm_read_data;
               out_valid_d = 1'b1;
               out_last_d  = (rd_idx_q == LAST_IDX);
               state_d     = OUT;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end

         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (rd_idx_q == LAST_IDX) begin
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
                  state_d  = READ_ISSUE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // every accepted beat becomes one core load on the following cycle
      if (accept_c) begin
         pm_load_coeff_d = 1'b1;
         pm_load_sel_d   = (load_idx_c >= N_B);
         pm_load_addr_d  = ADDR_WIDTH'(load_idx_c);
         if (in_data < Q_W) begin
            pm_load_data_d = in_data;
         end else begin
            pm_load_data_d = '0;
            range_err_d    = 1'b1;
         end
      end

      // LOAD always leaves on the 2N-th beat, so LOAD implies beat_cnt < 2N
      in_ready_d = (state_d == IDLE) || (state_d == LOAD);
      busy_d     = (state_d != IDLE);
   end

   // state, counter and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         beat_cnt_q      <= '0;
         rd_idx_q        <= '0;
         lat_cnt_q       <= '0;
         wd_cnt_q        <= '0;
         in_ready_q      <= 1'b0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_last_q      <= 1'b0;
         busy_q          <= 1'b0;
         frame_done_q    <= 1'b0;
         range_err_q     <= 1'b0;
         timeout_err_q   <= 1'b0;
         pm_start_q      <= 1'b0;
         pm_load_coeff_q <= 1'b0;
         pm_load_sel_q   <= 1'b0;
         pm_load_addr_q  <= '0;
         pm_load_data_q  <= '0;
         pm_read_addr_q  <= '0;
      end else begin
         state_q         <= state_d;
         beat_cnt_q      <= beat_cnt_d;
         rd_idx_q        <= rd_idx_d;
         lat_cnt_q       <= lat_cnt_d;
         wd_cnt_q        <= wd_cnt_d;
         in_ready_q      <= in_ready_d;
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         out_last_q      <= out_last_d;
         busy_q          <= busy_d;
         frame_done_q    <= frame_done_d;
         range_err_q     <= range_err_d;
         timeout_err_q   <= timeout_err_d;
         pm_start_q      <= pm_start_d;
         pm_load_coeff_q <= pm_load_coeff_d;
         pm_load_sel_q   <= pm_load_sel_d;
         pm_load_addr_q  <= pm_load_addr_d;
         pm_load_data_q  <= pm_load_data_d;
         pm_read_addr_q  <= pm_read_addr_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_last      = out_last_q;
   assign busy          = busy_q;
   assign frame_done    = frame_done_q;
   assign range_err     = range_err_q;
   assign timeout_err   = timeout_err_q;
   assign pm_start      = pm_start_q;
   assign pm_load_coeff = pm_load_coeff_q;
   assign pm_load_sel   = pm_load_sel_q;
   assign pm_load_addr  = pm_load_addr_q;
   assign pm_load_data  = pm_load_data_q;
   assign pm_read_addr  = pm_read_addr_q;

endmodule

// File: tb/tb_ntt_poly_mult_stream_ctrl.sv
// Directed bench for ntt_poly_mult_stream_ctrl with a behavioural
// negacyclic poly-mult core stub (sync read, RD_LAT=1).
module tb_ntt_poly_mult_stream_ctrl;

   localparam int unsigned N     = 256;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned Q     = 8380417;
   localparam int unsigned AW    = 8;
   localparam int unsigned TO    = 64;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last, busy, frame_done, range_err, timeout_err;
   logic             pm_start, pm_done, pm_load_coeff, pm_load_sel;
   logic [AW-1:0]    pm_load_addr, pm_read_addr;
   logic [WIDTH-1:0] pm_load_data, pm_read_data;

   always #5 clk = ~clk;

   ntt_poly_mult_stream_ctrl #(
      .N(N), .WIDTH(WIDTH), .Q(Q), .ADDR_WIDTH(AW), .RD_LAT(1), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .frame_done(frame_done), .range_err(range_err), .timeout_err(timeout_err),
      .pm_start(pm_start), .pm_done(pm_done), .pm_load_coeff(pm_load_coeff),
      .pm_load_sel(pm_load_sel), .pm_load_addr(pm_load_addr), .pm_load_data(pm_load_data),
      .pm_read_addr(pm_read_addr), .pm_read_data(pm_read_data)
   );

   int checks   = 0;
   int failures = 0;
   int fd_cnt   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // ---------------- core stub ----------------
   logic [WIDTH-1:0] stub_a [N];
   logic [WIDTH-1:0] stub_b [N];
   logic [WIDTH-1:0] stub_c [N];
   bit               stub_hang = 1'b0;
   int               stub_st;
   int               stub_cnt;

   task automatic stub_compute();
      longint unsigned acc [N];
      longint unsigned p;
      int              k;
      for (int i = 0; i < N; i++) acc[i] = 0;
      for (int i = 0; i < N; i++) begin
         if (stub_a[i] != 0) begin
            for (int j = 0; j < N; j++) begin
               if (stub_b[j] != 0) begin
                  p = (longint'(stub_a[i]) * longint'(stub_b[j])) % Q;
                  k = i + j;
                  if (k < N) acc[k] = (acc[k] + p) % Q;
                  else       acc[k - N] = (acc[k - N] + Q - p) % Q;
               end
            end
         end
      end
      for (int i = 0; i < N; i++) stub_c[i] = WIDTH'(acc[i]);
   endtask

   always @(posedge clk) begin
      if (pm_load_coeff) begin
         if (pm_load_sel) stub_b[pm_load_addr] <= pm_load_data;
         else             stub_a[pm_load_addr] <= pm_load_data;
      end
      pm_read_data <= stub_c[pm_read_addr];
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_st  <= 0;
         stub_cnt <= 0;
         pm_done  <= 1'b0;
      end else begin
         pm_done <= 1'b0;
         case (stub_st)
            0: if (pm_start && !stub_hang) begin
                  stub_compute();
                  stub_cnt <= 10;
                  stub_st  <= 1;
               end
            1: if (stub_cnt == 0) begin
                  pm_done <= 1'b1;
                  stub_st <= 2;
               end else begin
                  stub_cnt <= stub_cnt - 1;
               end
            default: if (!pm_start) stub_st <= 0;
         endcase
      end
   end

   always @(posedge clk) if (frame_done) fd_cnt++;

   // ---------------- frame data ----------------
   logic [WIDTH-1:0] fa    [2*N];
   logic [WIDTH-1:0] exp_c [N];

   task automatic clear_frame();
      for (int i = 0; i < 2 * N; i++) fa[i] = '0;
      for (int i = 0; i < N; i++) exp_c[i] = '0;
   endtask

   // drives beats fa[start..start+n-1]; returns at the negedge after the last handshake
   task automatic send_beats(input int start, input int n, input bit tail);
      int w;
      for (int i = start; i < start + n; i++) begin
         in_valid = 1'b1;
         in_data  = fa[i];
         w = 0;
         while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready) check("in_ready_wait", in_ready, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (tail) begin
         check("last_load_coeff", pm_load_coeff, 1);
         check("last_load_sel", pm_load_sel, 1);
         check("last_load_addr", pm_load_addr, N - 1);
         check("start_not_yet", pm_start, 0);
         @(negedge clk);
         check("start_rise", pm_start, 1);
      end
   endtask

   task automatic recv_frame(input bit rnd);
      int               k = 0;
      int               budget = 0;
      int               fd0 = fd_cnt;
      bit               stalled = 1'b0;
      bit               r;
      logic [WIDTH-1:0] held = '0;
      while (k < N && budget < 20000) begin
         @(negedge clk);
         budget++;
         if (out_valid) begin
            if (stalled) check("stall_stable", out_data, held);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (r) begin
               check($sformatf("C[%0d]", k), out_data, exp_c[k]);
               check($sformatf("last[%0d]", k), out_last, (k == N - 1));
               k++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = out_data;
            end
         end else begin
            if (stalled) check("valid_dropped", out_valid, 1);
            stalled   = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      if (k < N) check("recv_budget", k, N);
      @(negedge clk);
      out_ready = 1'b0;
      check("frame_done_pulse", frame_done, 1);
      check("busy_fall", busy, 0);
      @(negedge clk);
      check("frame_done_count", fd_cnt - fd0, 1);
      check("frame_done_low", frame_done, 0);
   endtask

   // first beat alone, then confirm both sticky errors were cleared
   task automatic send_checked_start();
      send_beats(0, 1, 1'b0);
      check("range_err_cleared", range_err, 0);
      check("timeout_err_cleared", timeout_err, 0);
      send_beats(1, 2 * N - 1, 1'b1);
   endtask

   function automatic logic [8:0] out_vec();
      return {in_ready, busy, out_valid, out_last, frame_done,
              range_err, timeout_err, pm_start, pm_load_coeff};
   endfunction

   initial begin
      int cyc;
      int fd0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", out_vec(), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_busy", busy, 0);

      // A=5, B=7 at index 0 -> C[0]=35
      clear_frame();
      fa[0] = 5; fa[N] = 7; exp_c[0] = 35;
      fork
         send_beats(0, 2 * N, 1'b1);
         recv_frame(1'b0);
      join

      // A[0]=1, B[k]=k+1 -> C[k]=k+1, random backpressure
      clear_frame();
      fa[0] = 1;
      for (int k = 0; k < N; k++) begin
         fa[N + k] = WIDTH'(k + 1);
         exp_c[k]  = WIDTH'(k + 1);
      end
      fork
         send_beats(0, 2 * N, 1'b1);
         recv_frame(1'b1);
      join

      // out-of-range beat 3; Q-1 still legal
      clear_frame();
      fa[0] = 2; fa[1] = Q - 1; fa[3] = Q; fa[N] = 3;
      exp_c[0] = 6; exp_c[1] = Q - 3;
      fork
         begin
            send_beats(0, 2 * N, 1'b1);
            check("range_err_set", range_err, 1);
         end
         recv_frame(1'b0);
      join
      check("range_err_sticky", range_err, 1);
      check("A3_zeroed", stub_a[3], 0);
      check("A1_kept", stub_a[1], Q - 1);

      // core never answers -> watchdog
      stub_hang = 1'b1;
      clear_frame();
      fa[0] = 9; fa[N] = 9;
      fd0 = fd_cnt;
      send_checked_start();
      cyc = 1;
      while (busy && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("watchdog_window", (cyc >= 64 && cyc <= 66), 1);
      check("timeout_err_set", timeout_err, 1);
      check("timeout_pm_start", pm_start, 0);
      check("timeout_busy", busy, 0);
      check("timeout_out_valid", out_valid, 0);
      check("timeout_no_done", fd_cnt - fd0, 0);
      stub_hang = 1'b0;
      @(negedge clk);

      // A=x, B=x -> C[2]=1
      clear_frame();
      fa[1] = 1; fa[N + 1] = 1; exp_c[2] = 1;
      fork
         send_checked_start();
         recv_frame(1'b0);
      join

      // reset after 100 beats, then a clean frame
      clear_frame();
      fa[2] = 3; fa[N + 5] = 4; exp_c[7] = 12;
      send_beats(0, 100, 1'b0);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("midframe_rst_outputs", out_vec(), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      fork
         send_beats(0, 2 * N, 1'b1);
         recv_frame(1'b1);
      join

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
